slow_dot_product_arbiter: RTL and testbench

//   Shares one slow_vector_dot_product unit between num_requesters clients (plane fit, distance test,

---
 rtl/ransac_fixed.sv | 27 ++
 rtl/rr_priority_picker.sv | 34 +++
 rtl/slow_dot_product_arbiter.sv | 137 +++++++++++++
 tb/tb_slow_dot_product_arbiter.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ransac_fixed.sv
// Shared fixed-point types for the RANSAC datapath, plus the arbiter state
// encoding so monitors can decode what the dot-product arbiter is doing.
package ransac_fixed;

  localparam int fixed_width = 32;

  typedef logic signed [fixed_width-1:0] fixed_t;

  typedef struct packed {
    fixed_t x;
    fixed_t y;
    fixed_t z;
  } vector3f_t;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESPOND
  } dp_arb_state_t;

  // Index width that stays legal for a single requester.
  function automatic int index_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational round-robin picker: first valid requester at or after rr_ptr,
// wrapping past the top index back to zero.
module rr_priority_picker
  import ransac_fixed::*;
#(
  parameter int num_requesters = 4
) (
  input  logic [num_requesters-1:0]               req_valid,
  input  logic [index_width(num_requesters)-1:0]  rr_ptr,
  output logic [index_width(num_requesters)-1:0]  pick,
  output logic                                    any_valid
);

  localparam int index_bits = index_width(num_requesters);

  logic [index_bits-1:0] cand [num_requesters];

  for (genvar gi = 0; gi < num_requesters; gi++) begin : g_cand
    assign cand[gi] = index_bits'((int'(rr_ptr) + gi) % num_requesters);
  end

  // Scan from the farthest offset down so the nearest valid candidate wins.
  always_comb begin
    pick      = '0;
    any_valid = 1'b0;
    for (int k = num_requesters - 1; k >= 0; k--) begin
      if (req_valid[cand[k]]) begin
        pick      = cand[k];
        any_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/slow_dot_product_arbiter.sv
// Round-robin front end that shares one slow vector dot-product unit between
// several RANSAC clients, one transaction in flight at a time.
module slow_dot_product_arbiter
  import ransac_fixed::*;
#(
  parameter int num_requesters = 4,
  parameter int timeout_cycles = 64
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic [num_requesters-1:0]       req_valid,
  input  vector3f_t [num_requesters-1:0]  req_lhs,
  input  vector3f_t [num_requesters-1:0]  req_rhs,
  output logic [num_requesters-1:0]       req_ready,
  output logic [num_requesters-1:0]       resp_valid,
  input  logic [num_requesters-1:0]       resp_ready,
  output fixed_t                          resp_dot_product,
  output logic                            dp_input_valid,
  output vector3f_t                       dp_lhs,
  output vector3f_t                       dp_rhs,
  input  logic                            dp_input_ready,
  input  logic                            dp_output_valid,
  input  fixed_t                          dp_dot_product,
  output logic                            busy,
  output logic                            timeout_error
);

  localparam int index_bits = index_width(num_requesters);
  localparam int count_bits = $clog2(timeout_cycles + 1);
  localparam logic [count_bits-1:0] count_limit = count_bits'(timeout_cycles);
  localparam logic [index_bits-1:0] last_index  = index_bits'(num_requesters - 1);

  dp_arb_state_t         state_reg,      state_next;
  logic [index_bits-1:0] rr_ptr_reg,     rr_ptr_next;
  logic [index_bits-1:0] grant_reg,      grant_next;
  vector3f_t             dp_lhs_reg,     dp_lhs_next;
  vector3f_t             dp_rhs_reg,     dp_rhs_next;
  fixed_t                result_reg,     result_next;
  logic [count_bits-1:0] wait_count_reg, wait_count_next;
  logic                  timeout_reg,    timeout_next;

  logic [index_bits-1:0] pick;
  logic                  any_valid;

  rr_priority_picker #(
    .num_requesters(num_requesters)
  ) u_picker (
    .req_valid (req_valid),
    .rr_ptr    (rr_ptr_reg),
    .pick      (pick),
    .any_valid (any_valid)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg      <= IDLE;
      rr_ptr_reg     <= '0;
      grant_reg      <= '0;
      dp_lhs_reg     <= '0;
      dp_rhs_reg     <= '0;
      result_reg     <= '0;
      wait_count_reg <= '0;
      timeout_reg    <= 1'b0;
    end else begin
      state_reg      <= state_next;
      rr_ptr_reg     <= rr_ptr_next;
      grant_reg      <= grant_next;
      dp_lhs_reg     <= dp_lhs_next;
      dp_rhs_reg     <= dp_rhs_next;
      result_reg     <= result_next;
      wait_count_reg <= wait_count_next;
      timeout_reg    <= timeout_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    rr_ptr_next     = rr_ptr_reg;
    grant_next      = grant_reg;
    dp_lhs_next     = dp_lhs_reg;
    dp_rhs_next     = dp_rhs_reg;
    result_next     = result_reg;
    wait_count_next = wait_count_reg;
    timeout_next    = timeout_reg;
    req_ready       = '0;

    case (state_reg)
      IDLE: begin
        if (any_valid) begin
          req_ready[pick] = 1'b1;
          grant_next      = pick;
          dp_lhs_next     = req_lhs[pick];
          dp_rhs_next     = req_rhs[pick];
          state_next      = ISSUE;
        end
      end
      ISSUE: begin
        if (dp_input_ready) begin
          wait_count_next = '0;
          state_next      = WAIT;
        end
      end
      WAIT: begin
        // wait_count==0 marks the first WAIT cycle, where output_valid may still be stale.
        if (wait_count_reg != '0 && dp_output_valid) begin
          result_next = dp_dot_product;
          state_next  = RESPOND;
        end
        if (wait_count_reg != count_limit) begin
          wait_count_next = wait_count_reg + 1'b1;
        end
        if (wait_count_next == count_limit) begin
          timeout_next = 1'b1;
        end
      end
      RESPOND: begin
        if (resp_ready[grant_reg]) begin
          rr_ptr_next = (grant_reg == last_index) ? '0 : grant_reg + 1'b1;
          state_next  = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  for (genvar gi = 0; gi < num_requesters; gi++) begin : g_resp
    assign resp_valid[gi] = (state_reg == RESPOND) && (grant_reg == index_bits'(gi));
  end

  assign dp_input_valid   = (state_reg == ISSUE);
  assign dp_lhs           = dp_lhs_reg;
  assign dp_rhs           = dp_rhs_reg;
  assign resp_dot_product = result_reg;
  assign busy             = (state_reg != IDLE);
  assign timeout_error    = timeout_reg;

endmodule

// File: tb/tb_slow_dot_product_arbiter.sv
// Bench for slow_dot_product_arbiter: behavioural stand-in for the shared
// dot-product unit, round-robin reference model and a response scoreboard.
module tb_slow_dot_product_arbiter;
  import ransac_fixed::*;

  localparam int N  = 4;
  localparam int TO = 64;

  logic clock = 1'b0;
  logic reset = 1'b0;

  logic [N-1:0]      req_valid = '0;
  vector3f_t [N-1:0] req_lhs   = '0;
  vector3f_t [N-1:0] req_rhs   = '0;
  logic [N-1:0]      req_ready;
  logic [N-1:0]      resp_valid;
  logic [N-1:0]      resp_ready = '1;
  fixed_t            resp_dot_product;
  logic              dp_input_valid;
  vector3f_t         dp_lhs, dp_rhs;
  logic              dp_input_ready;
  logic              dp_output_valid;
  fixed_t            dp_dot_product;
  logic              busy, timeout_error;

  always #5 clock = ~clock;

  slow_dot_product_arbiter #(.num_requesters(N), .timeout_cycles(TO)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_lhs(req_lhs), .req_rhs(req_rhs), .req_ready(req_ready),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_dot_product(resp_dot_product),
    .dp_input_valid(dp_input_valid), .dp_lhs(dp_lhs), .dp_rhs(dp_rhs),
    .dp_input_ready(dp_input_ready), .dp_output_valid(dp_output_valid),
    .dp_dot_product(dp_dot_product), .busy(busy), .timeout_error(timeout_error)
  );

  // ---------------- shared unit stand-in ----------------
  logic   stub_busy, stub_clear, force_nr = 1'b0, hang = 1'b0;
  int     stub_cnt;
  int     acc_cnt = 0;
  fixed_t stub_res;

  function automatic fixed_t fx_dot(input vector3f_t a, input vector3f_t b);
    longint s;
    s = ((longint'(a.x) * longint'(b.x)) >>> 16) + ((longint'(a.y) * longint'(b.y)) >>> 16)
      + ((longint'(a.z) * longint'(b.z)) >>> 16);
    return fixed_t'(s);
  endfunction

  assign dp_input_ready = !stub_busy && !force_nr;

  // output_valid is sticky and only falls one edge after the next accept.
  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      stub_busy       <= 1'b0;
      stub_clear      <= 1'b0;
      stub_cnt        <= 0;
      dp_output_valid <= 1'b0;
      dp_dot_product  <= '0;
      stub_res        <= '0;
    end else begin
      stub_clear <= 1'b0;
      if (stub_clear) dp_output_valid <= 1'b0;
      if (dp_input_valid && dp_input_ready) begin
        stub_busy  <= 1'b1;
        stub_clear <= 1'b1;
        stub_cnt   <= int'($urandom_range(2, 6));
        stub_res   <= fx_dot(dp_lhs, dp_rhs);
        acc_cnt    <= acc_cnt + 1;
      end else if (stub_busy && !hang) begin
        if (stub_cnt <= 1) begin
          stub_busy       <= 1'b0;
          dp_output_valid <= 1'b1;
          dp_dot_product  <= stub_res;
        end else begin
          stub_cnt <= stub_cnt - 1;
        end
      end
    end
  end

  // ---------------- reference model and scoreboard ----------------
  typedef struct {
    int     port;
    fixed_t val;
  } txn_t;

  txn_t      sb_q[$];
  fixed_t    exp_val [N];
  int        stall_until [N];
  int        m_rr = 0;
  int        cyc = 0;
  int        total = 0;
  int        bad = 0;
  bit        xfer = 0;
  int        xfer_port = 0;
  vector3f_t cur_lhs = '0, cur_rhs = '0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Operands are whole numbers, so the expected dot product is exact integer arithmetic.
  task automatic request(input int p, input int lx, input int ly, input int lz,
                         input int rx, input int ry, input int rz);
    req_lhs[p].x = fixed_t'(lx * 65536);
    req_lhs[p].y = fixed_t'(ly * 65536);
    req_lhs[p].z = fixed_t'(lz * 65536);
    req_rhs[p].x = fixed_t'(rx * 65536);
    req_rhs[p].y = fixed_t'(ry * 65536);
    req_rhs[p].z = fixed_t'(rz * 65536);
    exp_val[p]   = fixed_t'((lx * rx + ly * ry + lz * rz) * 65536);
    req_valid[p] = 1'b1;
    $display("req port=%0d lhs=(%0d,%0d,%0d) rhs=(%0d,%0d,%0d)", p, lx, ly, lz, rx, ry, rz);
  endtask

  function automatic int rnd();
    return int'($urandom_range(0, 200)) - 100;
  endfunction

  task automatic check_cycle();
    logic [N-1:0] exp_rdy;
    int pk;
    if (!reset) return;
    exp_rdy = '0;
    pk = -1;
    chk("busy", {127'd0, busy}, {127'd0, sb_q.size() != 0});
    if (sb_q.size() == 0) begin
      for (int k = 0; k < N; k++) begin
        if (req_valid[(m_rr + k) % N]) begin
          pk = (m_rr + k) % N;
          break;
        end
      end
      if (pk >= 0) exp_rdy[pk] = 1'b1;
    end
    chk("req_ready", {124'd0, req_ready}, {124'd0, exp_rdy});
    if (pk >= 0) begin
      sb_q.push_back('{port: pk, val: exp_val[pk]});
      cur_lhs   = req_lhs[pk];
      cur_rhs   = req_rhs[pk];
      xfer      = 1'b1;
      xfer_port = pk;
      $display("grant port=%0d", pk);
    end
    if (dp_input_valid) begin
      chk("dp_lhs", {32'd0, dp_lhs}, {32'd0, cur_lhs});
      chk("dp_rhs", {32'd0, dp_rhs}, {32'd0, cur_rhs});
    end
  endtask

  task automatic tick();
    @(negedge clock);
    check_cycle();
    @(posedge clock);
    #1;
    if (xfer) begin
      req_valid[xfer_port] = 1'b0;
      xfer = 1'b0;
    end
  endtask

  task automatic wait_idle(input int bound);
    int n = 0;
    while (!(sb_q.size() == 0 && req_valid == '0) && n < bound) begin
      tick();
      n++;
    end
    chk("idle_in_time", {127'd0, n < bound}, 128'd1);
  endtask

  task automatic check_reset_outputs();
    chk("rst_busy", {127'd0, busy}, 128'd0);
    chk("rst_resp_valid", {124'd0, resp_valid}, 128'd0);
    chk("rst_req_ready", {124'd0, req_ready}, 128'd0);
    chk("rst_dp_valid", {127'd0, dp_input_valid}, 128'd0);
    chk("rst_timeout", {127'd0, timeout_error}, 128'd0);
    chk("rst_result", {96'd0, resp_dot_product}, 128'd0);
    chk("rst_dp_lhs", {32'd0, dp_lhs}, 128'd0);
    chk("rst_dp_rhs", {32'd0, dp_rhs}, 128'd0);
  endtask

  // Monitor: compares whatever the DUT presents against the head of the scoreboard.
  initial begin : monitor
    bit hs;
    int hp;
    forever begin
      @(negedge clock);
      hs = 0;
      if (!reset) begin
        sb_q.delete();
        m_rr = 0;
      end else if (resp_valid != '0) begin
        if (sb_q.size() == 0) begin
          chk("spurious_resp", {124'd0, resp_valid}, 128'd0);
        end else begin
          chk("resp_port", {124'd0, resp_valid}, 128'd1 << sb_q[0].port);
          chk("resp_value", {96'd0, resp_dot_product}, {96'd0, sb_q[0].val});
          if (resp_ready[sb_q[0].port]) begin
            hs = 1;
            hp = sb_q[0].port;
          end
        end
      end
      @(posedge clock);
      if (hs && reset) begin
        $display("resp port=%0d value=%0h", hp, sb_q[0].val);
        void'(sb_q.pop_front());
        m_rr = (hp + 1) % N;
      end
      #1;
      for (int p = 0; p < N; p++) resp_ready[p] = (cyc >= stall_until[p]);
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int a0;
    for (int p = 0; p < N; p++) begin
      stall_until[p] = 0;
      exp_val[p]     = '0;
    end

    #12;
    check_reset_outputs();
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;

    // Single request: (1,2,3).(4,5,6) = 32.0
    request(0, 1, 2, 3, 4, 5, 6);
    wait_idle(200);
    chk("busy_after_single", {127'd0, busy}, 128'd0);

    // Serve port 3 so the pointer wraps back to 0, then all four at once.
    request(3, 2, 0, 1, 3, 7, -2);
    wait_idle(200);
    for (int p = 0; p < N; p++) request(p, rnd(), rnd(), rnd(), rnd(), rnd(), rnd());
    wait_idle(400);

    // Port 2 stalls its response while others queue up behind it.
    stall_until[2] = cyc + 40;
    request(2, rnd(), rnd(), rnd(), rnd(), rnd(), rnd());
    tick();
    tick();
    request(0, rnd(), rnd(), rnd(), rnd(), rnd(), rnd());
    request(3, rnd(), rnd(), rnd(), rnd(), rnd(), rnd());
    wait_idle(400);

    // Just-served port 1 re-requests alongside port 3: port 3 must go first.
    request(1, rnd(), rnd(), rnd(), rnd(), rnd(), rnd());
    wait_idle(200);
    request(1, rnd(), rnd(), rnd(), rnd(), rnd(), rnd());
    request(3, rnd(), rnd(), rnd(), rnd(), rnd(), rnd());
    wait_idle(400);

    // Randomised traffic with stalls and requests withdrawn before grant.
    for (int it = 0; it < 60; it++) begin
      for (int p = 0; p < N; p++) begin
        if (!req_valid[p] && $urandom_range(0, 2) == 0)
          request(p, rnd(), rnd(), rnd(), rnd(), rnd(), rnd());
      end
      if ($urandom_range(0, 3) == 0)
        stall_until[$urandom_range(0, N - 1)] = cyc + int'($urandom_range(1, 8));
      repeat ($urandom_range(1, 6)) tick();
      if ($urandom_range(0, 9) == 0) req_valid[$urandom_range(0, N - 1)] = 1'b0;
    end
    wait_idle(1000);

    // Shared unit not ready for 5 cycles, then it never produces a result.
    force_nr = 1'b1;
    a0 = acc_cnt;
    request(0, 3, 1, 4, 1, 5, 9);
    tick();
    repeat (5) begin
      chk("issue_held", {127'd0, dp_input_valid}, 128'd1);
      tick();
    end
    chk("no_accept_while_not_ready", 128'(acc_cnt), 128'(a0));
    force_nr = 1'b0;
    hang     = 1'b1;
    tick();
    chk("one_accept", 128'(acc_cnt), 128'(a0 + 1));
    repeat (TO - 1) tick();
    chk("timeout_before_limit", {127'd0, timeout_error}, 128'd0);
    tick();
    chk("timeout_at_limit", {127'd0, timeout_error}, 128'd1);
    repeat (3) tick();
    chk("timeout_sticky", {127'd0, timeout_error}, 128'd1);
    chk("still_one_accept", 128'(acc_cnt), 128'(a0 + 1));

    // Reset while stuck in WAIT: outputs clear immediately, transaction dropped.
    #2;
    reset = 1'b0;
    #1;
    check_reset_outputs();
    hang      = 1'b0;
    req_valid = '0;
    xfer      = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    request(2, -4, 6, 8, 5, 1, -3);
    wait_idle(200);
    chk("timeout_clear_after_reset", {127'd0, timeout_error}, 128'd0);
    repeat (5) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
